// File: rtl/const_seq_pkg.sv
// Shared types and sizing helpers for the constant-sequence source.
package const_seq_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StDelay,
    StEmit
  } state_e;

  localparam int unsigned DEPTH_DEF = 4;

  function automatic int unsigned len_width(int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int unsigned idx_width(int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  localparam int unsigned LEN_W = len_width(DEPTH_DEF);
  localparam int unsigned IDX_W = idx_width(DEPTH_DEF);

  // A length of 0 still plays one slot; oversize lengths saturate at the slot count.
  function automatic int unsigned clamp_len(int unsigned len, int unsigned depth);
    if (len == 0) return 1;
    if (len > depth) return depth;
    return len;
  endfunction

endpackage

// File: rtl/const_seq_if.sv
// Control, configuration and data signals between a sequence consumer and const_seq.
interface const_seq_if #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned PERIOD_W = 8,
  parameter int unsigned ITER_W   = 8,
  parameter int unsigned DELAY_W  = 8
) ();

  logic                                         running;
  logic                                         run;
  logic                                         done;
  logic [DATA_W-1:0]                            out0;
  logic [DEPTH*DATA_W-1:0]                      constants;
  logic [const_seq_pkg::len_width(DEPTH)-1:0]   length;
  logic [PERIOD_W-1:0]                          period;
  logic [ITER_W-1:0]                            iterations;
  logic [DELAY_W-1:0]                           delay;

  modport master (
    output running, run, constants, length, period, iterations, delay,
    input  done, out0
  );

  modport slave (
    input  running, run, constants, length, period, iterations, delay,
    output done, out0
  );

endinterface

// File: rtl/const_seq_cnt.sv
// Loadable down-counter with enable and zero flag; load has priority over decrement.
module const_seq_cnt #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (en) begin
      if (load) begin
        count_q <= load_val;
      end else if (dec && (count_q != '0)) begin
        count_q <= count_q - W'(1);
      end
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/const_seq.sv
// Programmable constant-sequence source: plays up to DEPTH latched constants, each held
// period+1 cycles, after a start delay, iterations+1 times.
module const_seq import const_seq_pkg::*; #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned PERIOD_W = 8,
  parameter int unsigned ITER_W   = 8,
  parameter int unsigned DELAY_W  = 8
) (
  input logic         clk,
  input logic         rst,
  const_seq_if.slave  bus
);

  localparam int unsigned SEQ_IDX_W = idx_width(DEPTH);

  state_e                state_q;
  logic [SEQ_IDX_W-1:0]  idx_q;
  logic [SEQ_IDX_W-1:0]  idx_next;
  logic [SEQ_IDX_W-1:0]  last_idx_q;
  logic [SEQ_IDX_W-1:0]  cfg_last_idx;
  logic [DATA_W-1:0]     slot_q [DEPTH];
  logic [PERIOD_W-1:0]   period_q;
  logic [DATA_W-1:0]     out0_q;
  logic                  done_q;

  logic                  accept;
  logic                  is_last;
  logic                  delay_zero;
  logic                  hold_zero;
  logic                  iter_zero;
  logic                  delay_load;
  logic                  delay_dec;
  logic [DELAY_W-1:0]    delay_load_val;
  logic                  hold_load;
  logic                  hold_dec;
  logic [PERIOD_W-1:0]   hold_load_val;
  logic                  iter_dec;

  assign accept       = bus.running & bus.run;
  assign is_last      = (idx_q == last_idx_q);
  assign idx_next     = idx_q + SEQ_IDX_W'(1);
  assign cfg_last_idx = SEQ_IDX_W'(clamp_len(32'(bus.length), DEPTH) - 1);

  // Counter controls; a restart (accept) overrides whatever the current state wants.
  always_comb begin
    delay_load     = accept;
    delay_load_val = (bus.delay == '0) ? '0 : bus.delay - DELAY_W'(1);
    delay_dec      = !accept && (state_q == StDelay);

    hold_load      = 1'b0;
    hold_load_val  = period_q;
    hold_dec       = !accept && (state_q == StEmit);
    if (accept) begin
      hold_load     = (bus.delay == '0);
      hold_load_val = bus.period;
    end else if (state_q == StDelay) begin
      hold_load = delay_zero;
    end else if (state_q == StEmit) begin
      hold_load = hold_zero && !(is_last && iter_zero);
    end

    iter_dec = !accept && (state_q == StEmit) && hold_zero && is_last;
  end

  const_seq_cnt #(.W(DELAY_W)) u_delay_cnt (
    .clk      (clk),
    .rst      (rst),
    .en       (bus.running),
    .load     (delay_load),
    .load_val (delay_load_val),
    .dec      (delay_dec),
    .zero     (delay_zero)
  );

  const_seq_cnt #(.W(PERIOD_W)) u_hold_cnt (
    .clk      (clk),
    .rst      (rst),
    .en       (bus.running),
    .load     (hold_load),
    .load_val (hold_load_val),
    .dec      (hold_dec),
    .zero     (hold_zero)
  );

  const_seq_cnt #(.W(ITER_W)) u_iter_cnt (
    .clk      (clk),
    .rst      (rst),
    .en       (bus.running),
    .load     (accept),
    .load_val (bus.iterations),
    .dec      (iter_dec),
    .zero     (iter_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      last_idx_q <= '0;
      period_q   <= '0;
      out0_q     <= '0;
      done_q     <= 1'b1;
      for (int k = 0; k < DEPTH; k++) slot_q[k] <= '0;
    end else if (bus.running) begin
      if (bus.run) begin
        for (int k = 0; k < DEPTH; k++) slot_q[k] <= bus.constants[k*DATA_W +: DATA_W];
        last_idx_q <= cfg_last_idx;
        period_q   <= bus.period;
        idx_q      <= '0;
        done_q     <= 1'b0;
        if (bus.delay == '0) begin
          state_q <= StEmit;
          out0_q  <= bus.constants[DATA_W-1:0];
        end else begin
          state_q <= StDelay;
        end
      end else begin
        unique case (state_q)
          StDelay: begin
            if (delay_zero) begin
              state_q <= StEmit;
              out0_q  <= slot_q[0];
            end
          end
          StEmit: begin
            if (hold_zero) begin
              if (!is_last) begin
                idx_q  <= idx_next;
                out0_q <= slot_q[idx_next];
              end else if (!iter_zero) begin
                idx_q  <= '0;
                out0_q <= slot_q[0];
              end else begin
                state_q <= StIdle;
                done_q  <= 1'b1;
              end
            end
          end
          StIdle: ;
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign bus.out0 = out0_q;
  assign bus.done = done_q;

endmodule
